// File: rtl/fp64_to_int_pipe.sv
// rtl/fp64_to_int_pipe.sv - three-stage IEEE-754 binary64 to integer converter, per-beat rounding mode
module fp64_to_int_pipe #(
  parameter int OUT_WIDTH  = 64,
  parameter int SIGNED_OUT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a_tvalid,
  input  logic [63:0]          a_tdata,
  input  logic [1:0]           a_tuser,
  output logic                 a_tready,
  output logic                 result_tvalid,
  output logic [OUT_WIDTH-1:0] result_tdata,
  output logic [2:0]           result_tuser,
  input  logic                 result_tready
);

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTN = 2'b10;
  localparam logic [1:0] RM_RTP = 2'b11;

  // Largest magnitude allowed for each sign before saturating.
  localparam logic [64:0] LIM_POS = (SIGNED_OUT != 0) ? ((65'd1 << (OUT_WIDTH-1)) - 65'd1)
                                                      : ((65'd1 << OUT_WIDTH) - 65'd1);
  localparam logic [64:0] LIM_NEG = (SIGNED_OUT != 0) ? (65'd1 << (OUT_WIDTH-1)) : 65'd0;
  localparam logic [OUT_WIDTH-1:0] MAX_VAL = (SIGNED_OUT != 0) ? {1'b0, {(OUT_WIDTH-1){1'b1}}}
                                                               : {OUT_WIDTH{1'b1}};
  localparam logic [OUT_WIDTH-1:0] MIN_VAL = (SIGNED_OUT != 0) ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                                               : {OUT_WIDTH{1'b0}};

  localparam logic [10:0] EXP_BIG    = 11'd1087;
  localparam logic [10:0] EXP_SMALL  = 11'd1022;
  localparam logic [10:0] EXP_SHIFT0 = 11'd1086;

  logic w_en;
  assign w_en     = result_tready | ~result_tvalid;
  assign a_tready = w_en;

  logic        r1_valid;
  logic        r1_sign;
  logic        r1_nan;
  logic [10:0] r1_exp;
  logic [52:0] r1_mant;
  logic [1:0]  r1_mode;

  always_ff @(posedge clk) begin
    if (rst) begin
      r1_valid <= 1'b0;
    end else if (w_en) begin
      r1_valid <= a_tvalid;
      r1_sign  <= a_tdata[63];
      r1_exp   <= a_tdata[62:52];
      r1_mant  <= {|a_tdata[62:52], a_tdata[51:0]};
      r1_nan   <= (&a_tdata[62:52]) & (|a_tdata[51:0]);
      r1_mode  <= a_tuser;
    end
  end

  // Hidden bit sits at bit 127; shifting right by (63 - e) lands it at bit 64+e, so
  // [127:64] is the integer part, bit 63 the guard and [62:0] the sticky field.
  logic [10:0]  w_shamt;
  logic [127:0] w_shifted;
  logic         w_big;
  logic         w_small;
  logic [63:0]  w_int;
  logic         w_guard;
  logic         w_sticky;

  assign w_shamt   = EXP_SHIFT0 - r1_exp;
  assign w_shifted = {r1_mant, 75'd0} >> w_shamt;
  assign w_big     = (r1_exp >= EXP_BIG);
  assign w_small   = (r1_exp < EXP_SMALL);

  always_comb begin
    w_int    = w_shifted[127:64];
    w_guard  = w_shifted[63];
    w_sticky = |w_shifted[62:0];
    if (w_big || w_small) begin
      w_int    = 64'd0;
      w_guard  = 1'b0;
      w_sticky = w_small & (|r1_mant);
    end
  end

  logic        r2_valid;
  logic        r2_sign;
  logic        r2_nan;
  logic        r2_big;
  logic [1:0]  r2_mode;
  logic [63:0] r2_int;
  logic        r2_guard;
  logic        r2_sticky;

  always_ff @(posedge clk) begin
    if (rst) begin
      r2_valid <= 1'b0;
    end else if (w_en) begin
      r2_valid  <= r1_valid;
      r2_sign   <= r1_sign;
      r2_nan    <= r1_nan;
      r2_big    <= w_big;
      r2_mode   <= r1_mode;
      r2_int    <= w_int;
      r2_guard  <= w_guard;
      r2_sticky <= w_sticky;
    end
  end

  logic                 w_inc;
  logic [64:0]          w_mag;
  logic                 w_ovf;
  logic [OUT_WIDTH-1:0] w_trunc;
  logic [OUT_WIDTH-1:0] w_conv;

  always_comb begin
    w_inc = 1'b0;
    case (r2_mode)
      RM_RNE:  w_inc = r2_guard & (r2_sticky | r2_int[0]);
      RM_RTN:  w_inc = r2_sign & (r2_guard | r2_sticky);
      RM_RTP:  w_inc = ~r2_sign & (r2_guard | r2_sticky);
      default: w_inc = 1'b0;
    endcase
  end

  // Saturation is judged on the rounded magnitude so -2^(N-1) stays representable.
  assign w_mag   = {1'b0, r2_int} + {64'd0, w_inc};
  assign w_ovf   = r2_big | (r2_sign ? (w_mag > LIM_NEG) : (w_mag > LIM_POS));
  assign w_trunc = w_mag[OUT_WIDTH-1:0];
  assign w_conv  = r2_sign ? (OUT_WIDTH'(0) - w_trunc) : w_trunc;

  always_ff @(posedge clk) begin
    if (rst) begin
      result_tvalid <= 1'b0;
      result_tdata  <= '0;
      result_tuser  <= 3'b000;
    end else if (w_en) begin
      result_tvalid <= r2_valid;
      if (r2_valid) begin
        if (r2_nan) begin
          result_tdata <= MAX_VAL;
          result_tuser <= 3'b100;
        end else if (w_ovf) begin
          result_tdata <= r2_sign ? MIN_VAL : MAX_VAL;
          result_tuser <= 3'b010;
        end else begin
          result_tdata <= w_conv;
          result_tuser <= {2'b00, r2_guard | r2_sticky};
        end
      end
    end
  end

endmodule

// File: tb/tb_fp64_to_int_pipe.sv
// tb/tb_fp64_to_int_pipe.sv - self-checking bench for fp64_to_int_pipe (32-bit signed and 64-bit unsigned)
module tb_fp64_to_int_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_tvalid;
  logic [63:0] a_tdata;
  logic [1:0]  a_tuser;
  logic        result_tready;

  logic        a_tready_s, rv_s;
  logic [31:0] rd_s;
  logic [2:0]  ru_s;
  logic        a_tready_u, rv_u;
  logic [63:0] rd_u;
  logic [2:0]  ru_u;

  fp64_to_int_pipe #(.OUT_WIDTH(32), .SIGNED_OUT(1)) u_s32 (
    .clk(clk), .rst(rst), .a_tvalid(a_tvalid), .a_tdata(a_tdata), .a_tuser(a_tuser),
    .a_tready(a_tready_s), .result_tvalid(rv_s), .result_tdata(rd_s), .result_tuser(ru_s),
    .result_tready(result_tready));

  fp64_to_int_pipe #(.OUT_WIDTH(64), .SIGNED_OUT(0)) u_u64 (
    .clk(clk), .rst(rst), .a_tvalid(a_tvalid), .a_tdata(a_tdata), .a_tuser(a_tuser),
    .a_tready(a_tready_u), .result_tvalid(rv_u), .result_tdata(rd_u), .result_tuser(ru_u),
    .result_tready(result_tready));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: exact real arithmetic on the operand value, then range check against 2^k bounds.
  function automatic void model(input logic [63:0] bits, input logic [1:0] mode, input int w,
                                input bit sgn, output logic [63:0] data, output logic [2:0] flags);
    real x, fl, r, f, hi, lo, p;
    logic [63:0] mx, mn;
    p = 1.0;
    for (int i = 0; i < w - 1; i++) p = p * 2.0;
    hi = sgn ? p : 2.0 * p;
    lo = sgn ? -p : 0.0;
    mn = sgn ? (64'd1 << (w - 1)) : 64'd0;
    mx = sgn ? ((64'd1 << (w - 1)) - 64'd1) : {64{1'b1}};
    if (bits[62:52] == 11'h7ff && bits[51:0] != 52'd0) begin
      data  = mx;
      flags = 3'b100;
      return;
    end
    x  = $bitstoreal(bits);
    fl = $floor(x);
    case (mode)
      2'b00: begin
        f = x - fl;
        if (f > 0.5) r = fl + 1.0;
        else if (f < 0.5) r = fl;
        else r = ($floor(fl / 2.0) == fl / 2.0) ? fl : fl + 1.0;
      end
      2'b01:   r = (x < 0.0) ? $ceil(x) : fl;
      2'b10:   r = fl;
      default: r = $ceil(x);
    endcase
    if (r >= hi) begin
      data  = mx;
      flags = 3'b010;
    end else if (r < lo) begin
      data  = mn;
      flags = 3'b010;
    end else begin
      if (r >= 9223372036854775808.0)
        data = 64'(longint'(r - 9223372036854775808.0)) ^ 64'h8000_0000_0000_0000;
      else
        data = 64'(longint'(r));
      flags = {2'b00, (r != x)};
    end
  endfunction

  task automatic pin(input string n, input logic [63:0] b, input logic [1:0] m, input int w,
                     input bit s, input logic [63:0] ed, input logic [2:0] ef);
    logic [63:0] d, mask;
    logic [2:0]  f;
    model(b, m, w, s, d, f);
    mask = (w == 64) ? {64{1'b1}} : 64'h0000_0000_FFFF_FFFF;
    chk({n, "_data"}, d & mask, ed);
    chk({n, "_flags"}, {61'd0, f}, {61'd0, ef});
  endtask

  function automatic logic [63:0] gen();
    logic [63:0] rnd;
    logic [10:0] e;
    logic [51:0] f;
    int          sel;
    rnd = {$urandom, $urandom};
    f   = rnd[51:0];
    sel = $urandom_range(0, 15);
    case (sel)
      0:       begin e = 11'd0; f = 52'd0; end
      1:       e = 11'd0;
      2:       begin e = 11'd2047; f = 52'd0; end
      3:       begin e = 11'd2047; f = f | 52'd1; end
      4, 5:    begin e = 11'(1022 + $urandom_range(0, 8)); f = f & {8'hff, 44'd0}; end
      6, 7:    e = 11'(1051 + $urandom_range(0, 6));
      8, 9:    e = 11'(1083 + $urandom_range(0, 6));
      default: e = 11'(1000 + $urandom_range(0, 90));
    endcase
    return {rnd[63], e, f};
  endfunction

  typedef struct {
    logic [63:0] bits;
    logic [1:0]  mode;
    int          cyc;
    int          stalls;
  } beat_t;

  beat_t       q[$];
  int          cyc = 0;
  int          stalls = 0;
  logic [63:0] e_d;
  logic [2:0]  e_f;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      q.delete();
    end else begin
      chk("a_tready_rule", {63'd0, a_tready_s}, {63'd0, result_tready | ~rv_s});
      chk("tvalid_u64", {63'd0, rv_u}, {63'd0, rv_s});
      if (rv_s) begin
        chk("beat_pending", {63'd0, q.size() > 0}, 64'd1);
        if (q.size() > 0) begin
          model(q[0].bits, q[0].mode, 32, 1'b1, e_d, e_f);
          chk("s32_data", {32'd0, rd_s}, {32'd0, e_d[31:0]});
          chk("s32_flags", {61'd0, ru_s}, {61'd0, e_f});
          model(q[0].bits, q[0].mode, 64, 1'b0, e_d, e_f);
          chk("u64_data", rd_u, e_d);
          chk("u64_flags", {61'd0, ru_u}, {61'd0, e_f});
          if (result_tready) begin
            chk("latency", 64'(cyc - q[0].cyc), 64'(3 + stalls - q[0].stalls));
            void'(q.pop_front());
          end
        end
      end
      if (a_tvalid && a_tready_s) q.push_back('{a_tdata, a_tuser, cyc, stalls});
      if (!a_tready_s) stalls++;
    end
  end

  task automatic send(input logic [63:0] b, input logic [1:0] m);
    a_tvalid = 1'b1;
    a_tdata  = b;
    a_tuser  = m;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (a_tready_s) break;
    end
    chk("send_ready", {63'd0, a_tready_s}, 64'd1);
    @(posedge clk);
    #1;
    a_tvalid = 1'b0;
  endtask

  task automatic drain();
    a_tvalid      = 1'b0;
    result_tready = 1'b1;
    for (int k = 0; k < 100 && q.size() != 0; k++) @(negedge clk);
    chk("drain_empty", 64'(q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  logic [63:0] dir_b[18] = '{
    64'h4004000000000000, 64'h4004000000000000, 64'hBFF8000000000000, 64'hBFF8000000000000,
    64'h41E0000000000000, 64'hC1E0000000000000, 64'h7FF8000000000000, 64'hC000000000000000,
    64'h0000000000000001, 64'h3FE0000000000000, 64'h3FF8000000000000, 64'h8000000000000000,
    64'h7FF0000000000000, 64'hFFF0000000000000, 64'hBFD3333333333333, 64'h43EFFFFFFFFFFFFF,
    64'hC3E0000000000000, 64'h43F0000000000000};
  logic [1:0] dir_m[18] = '{
    2'd0, 2'd3, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3,
    2'd0, 2'd0, 2'd2, 2'd1, 2'd3, 2'd1, 2'd0, 2'd0, 2'd0};

  logic [63:0] bp[6];
  logic        acc;
  int          idx;
  int          sent;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; a_tvalid = 1'b0; a_tdata = 64'd0; a_tuser = 2'd0; result_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_tvalid", {63'd0, rv_s}, 64'd0);
    chk("rst_tdata_s32", {32'd0, rd_s}, 64'd0);
    chk("rst_tuser_s32", {61'd0, ru_s}, 64'd0);
    chk("rst_tdata_u64", rd_u, 64'd0);
    chk("rst_a_tready", {63'd0, a_tready_s}, 64'd1);

    pin("pin_2p5_rne",   64'h4004000000000000, 2'd0, 32, 1'b1, 64'h2,        3'b001);
    pin("pin_2p5_ceil",  64'h4004000000000000, 2'd3, 32, 1'b1, 64'h3,        3'b001);
    pin("pin_m1p5_rtz",  64'hBFF8000000000000, 2'd1, 32, 1'b1, 64'hFFFFFFFF, 3'b001);
    pin("pin_m1p5_flr",  64'hBFF8000000000000, 2'd2, 32, 1'b1, 64'hFFFFFFFE, 3'b001);
    pin("pin_2p31",      64'h41E0000000000000, 2'd0, 32, 1'b1, 64'h7FFFFFFF, 3'b010);
    pin("pin_m2p31",     64'hC1E0000000000000, 2'd0, 32, 1'b1, 64'h80000000, 3'b000);
    pin("pin_nan",       64'h7FF8000000000000, 2'd0, 32, 1'b1, 64'h7FFFFFFF, 3'b100);
    pin("pin_u_m2",      64'hC000000000000000, 2'd0, 64, 1'b0, 64'h0,        3'b010);
    pin("pin_u_dnm",     64'h0000000000000001, 2'd3, 64, 1'b0, 64'h1,        3'b001);
    pin("pin_u_m0p3",    64'hBFD3333333333333, 2'd1, 64, 1'b0, 64'h0,        3'b001);

    for (int i = 0; i < 18; i++) send(dir_b[i], dir_m[i]);
    drain();

    for (int i = 0; i < 6; i++) bp[i] = gen();
    result_tready = 1'b0;
    idx = 0;
    a_tvalid = 1'b1; a_tdata = bp[0]; a_tuser = 2'($urandom_range(0, 3));
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      acc = a_tready_s;
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        if (idx < 6) begin a_tdata = bp[idx]; a_tuser = 2'($urandom_range(0, 3)); end
      end
    end
    chk("bp_accepted", 64'(idx), 64'd3);
    @(negedge clk);
    chk("bp_a_tready_low", {63'd0, a_tready_s}, 64'd0);
    chk("bp_tvalid_high", {63'd0, rv_s}, 64'd1);
    repeat (3) @(posedge clk);
    #1;
    result_tready = 1'b1;
    for (int c = 0; c < 60 && idx < 6; c++) begin
      @(negedge clk);
      acc = a_tready_s;
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        if (idx < 6) begin a_tdata = bp[idx]; a_tuser = 2'($urandom_range(0, 3)); end
      end
    end
    a_tvalid = 1'b0;
    chk("bp_all_accepted", 64'(idx), 64'd6);
    drain();

    send(64'h4004000000000000, 2'd0);
    send(64'hC1E0000000000000, 2'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_tvalid", {63'd0, rv_s}, 64'd0);
    repeat (5) @(negedge clk);
    chk("midrst_quiet", {63'd0, rv_s}, 64'd0);
    @(posedge clk);
    #1;
    send(64'h3FF8000000000000, 2'd2);
    drain();

    sent = 0;
    a_tvalid = 1'b0;
    for (int n = 0; n < 4000 && sent < 400; n++) begin
      @(negedge clk);
      acc = a_tvalid & a_tready_s;
      @(posedge clk);
      #1;
      if (acc) sent++;
      if (!a_tvalid || acc) begin
        a_tvalid = ($urandom_range(0, 3) != 0);
        a_tdata  = gen();
        a_tuser  = 2'($urandom_range(0, 3));
      end
      result_tready = ($urandom_range(0, 9) < 7);
    end
    chk("rand_sent", 64'(sent), 64'd400);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
